// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the FIFO-to-UART transmit controller.
package fifo_tx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMR_W  = 16;

  localparam int unsigned DEF_RD_LATENCY  = 1;
  localparam int unsigned DEF_GAP_CYCLES  = 2;
  localparam int unsigned DEF_ACK_TIMEOUT = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WAIT_DATA = 3'd2,
    LAUNCH    = 3'd3,
    WAIT_ACK  = 3'd4,
    DRAIN     = 3'd5,
    GAP       = 3'd6
  } state_t;

endpackage

// File: rtl/fifo_tx_ctrl_timer.sv
// Loadable down-counter shared by the ACK timeout and the inter-byte gap.
module cycle_timer
  import fifo_tx_pkg::*;
#(
  parameter int unsigned WIDTH = TMR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             count,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fifo_tx_ctrl.sv
// Pulls bytes from a FIFO read port and launches them one at a time into a
// UART transmitter, waiting for its busy handshake and an idle gap between bytes.
module fifo_tx_ctrl
  import fifo_tx_pkg::*;
#(
  parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rd_empty,
  output logic              rd_req,
  input  logic [BYTE_W-1:0] rd_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              ack_err,
  output logic              idle
);

  localparam int unsigned GAP_LEN = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  // Timer is loaded in LAUNCH, so the LAUNCH cycle counts toward the timeout.
  localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'((ACK_TIMEOUT > 2) ? ACK_TIMEOUT - 2 : 0);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_LEN - 1);
  localparam logic [1:0]       LAT_LOAD = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  state_t            state, state_next;
  logic [1:0]        lat_cnt;
  logic              capture;
  logic              set_err;
  logic              tmr_load;
  logic              tmr_count;
  logic [TMR_W-1:0]  tmr_load_val;
  logic              tmr_zero;

  cycle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .count    (tmr_count),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      tx_data  <= '0;
      byte_cnt <= '0;
      ack_err  <= 1'b0;
      idle     <= 1'b1;
    end else begin
      state <= state_next;
      idle  <= (state_next == IDLE);
      if (state == READ) begin
        lat_cnt <= LAT_LOAD;
      end else if ((state == WAIT_DATA) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (capture) begin
        tx_data <= rd_data;
      end
      if (state == LAUNCH) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (set_err) begin
        ack_err <= 1'b1;
      end
    end
  end

  // Strobes are gated with rst so a reset cycle never pops or launches a byte.
  always_comb begin
    state_next   = state;
    rd_req       = 1'b0;
    tx_start     = 1'b0;
    capture      = 1'b0;
    set_err      = 1'b0;
    tmr_load     = 1'b0;
    tmr_count    = 1'b0;
    tmr_load_val = '0;
    unique case (state)
      IDLE: begin
        if (enable && !rd_empty && !tx_busy) begin
          state_next = READ;
        end
      end
      READ: begin
        rd_req = !rd_empty && !rst;
        if (rd_empty) begin
          state_next = IDLE;
        end else if (RD_LATENCY <= 1) begin
          capture    = 1'b1;
          state_next = LAUNCH;
        end else begin
          state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (lat_cnt == '0) begin
          capture    = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start     = !rst;
        tmr_load     = 1'b1;
        tmr_load_val = ACK_LOAD;
        state_next   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = DRAIN;
        end else if (tmr_zero) begin
          set_err      = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
          state_next   = GAP;
        end else begin
          tmr_count = 1'b1;
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
          state_next   = GAP;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_next = IDLE;
        end else begin
          tmr_count = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_tx_ctrl.sv
// Directed and randomized bench for fifo_tx_ctrl with a show-ahead FIFO model,
// a UART busy responder and a transaction-level expectation model.
module tb_fifo_tx_ctrl;

  localparam int RDL     = 1;
  localparam int GAP     = 2;
  localparam int ACKT    = 8;
  localparam int GAP_LEN = (GAP == 0) ? 1 : GAP;
  localparam int MIN_SEP = 3 + GAP + RDL;

  logic        clk = 1'b0;
  logic        rst, enable, rd_empty, rd_req, tx_busy, tx_start, ack_err, idle;
  logic [7:0]  rd_data, tx_data;
  logic [15:0] byte_cnt;

  always #5 clk = ~clk;

  fifo_tx_ctrl #(
    .RD_LATENCY  (RDL),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (ACKT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rd_empty (rd_empty),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .byte_cnt (byte_cnt),
    .ack_err  (ack_err),
    .idle     (idle)
  );

  typedef struct {
    logic [7:0] data;
    int         c;
  } launch_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          reads = 0;
  int          n_launch = 0;
  int          last_launch = -100;
  int          busy_left = 0;
  int          busy_len = 10;
  bit          rand_busy = 0;
  bit          dead_seen = 0;
  bit          force_empty = 0;
  bit          have_prev = 0;
  logic        prev_rst = 1'b1;
  logic [7:0]  prev_tx_data = 8'h00;
  logic [15:0] exp_cnt = 16'h0000;
  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  launch_t     log_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rd_empty = force_empty || (fifo_q.size() == 0);
    rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic tick();
    logic       s_req, s_start;
    logic [7:0] s_data;
    #1;
    s_req   = rd_req;
    s_start = tx_start;
    s_data  = tx_data;
    if (have_prev && (s_data !== prev_tx_data) && !prev_rst)
      check("tx_data_hold", s_start, 1'b1);
    prev_tx_data = s_data;
    prev_rst     = rst;
    have_prev    = 1;
    @(posedge clk);
    #1;
    if (s_req) begin
      check("rd_req_nonempty", (fifo_q.size() != 0), 1'b1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      reads++;
    end
    if (s_start) begin
      n_launch++;
      last_launch = cyc;
      log_q.push_back('{s_data, cyc});
      exp_cnt++;
      busy_left = rand_busy ? int'($urandom_range(0, 6)) : busy_len;
      if (busy_left == 0) dead_seen = 1;
    end
    cyc++;
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
    refresh();
  endtask

  task automatic wait_launch(input string tag, input int budget, output int lc, output logic [7:0] d);
    int n0;
    n0 = n_launch;
    for (int i = 0; i < budget && n_launch == n0; i++) tick();
    check({tag, "_seen"}, (n_launch != n0), 1'b1);
    lc = last_launch;
    d  = (log_q.size() != 0) ? log_q[$].data : 8'h00;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && !(idle === 1'b1 && busy_left == 0 && tx_busy == 1'b0); i++) tick();
    check(tag, (idle === 1'b1 && busy_left == 0), 1'b1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    busy_left = 0;
    tick();
    tick();
    check("rst_idle", idle, 1'b1);
    check("rst_byte_cnt", byte_cnt, 16'h0000);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    rst = 1'b0;
    exp_cnt = 16'h0000;
    dead_seen = 0;
    log_q.delete();
  endtask

  initial begin
    int         L, L2, c0, r0, n0, prevc, pushed;
    logic [7:0] d, b;
    launch_t    e;

    rst = 1'b1;
    enable = 1'b0;
    tx_busy = 1'b0;
    refresh();
    reset_dut();
    enable = 1'b1;

    // Single byte with a 10-cycle busy response.
    busy_len = 10;
    fifo_q.push_back(8'hA5);
    refresh();
    c0 = cyc;
    wait_launch("s1_launch", 20, L, d);
    check("s1_launch_cyc", L, c0 + 1 + RDL);
    check("s1_data", d, 8'hA5);
    check("s1_byte_cnt", byte_cnt, exp_cnt);
    while (cyc < L + 1 + busy_len + GAP_LEN) tick();
    check("s1_idle_early", idle, 1'b0);
    tick();
    check("s1_idle_back", idle, 1'b1);
    check("s1_reads", reads, 1);

    // Back-to-back bytes.
    reset_dut();
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03);
    refresh();
    prevc = cyc + 1 + RDL - (busy_len + 3 + GAP_LEN + RDL);
    for (int k = 0; k < 3; k++) begin
      wait_launch("b2b_launch", 60, L, d);
      check("b2b_cyc", L, prevc + busy_len + 3 + GAP_LEN + RDL);
      check("b2b_data", d, 8'(k + 1));
      prevc = L;
    end
    check("b2b_byte_cnt", byte_cnt, 16'd3);

    // ACK timeout with a dead UART.
    wait_idle("to_idle0", 60);
    busy_len = 0;
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h3C);
    refresh();
    wait_launch("to_launch1", 20, L, d);
    check("to_data1", d, 8'h5A);
    while (cyc < L + ACKT - 1) tick();
    check("to_ack_err_before", ack_err, 1'b0);
    tick();
    check("to_ack_err_at", ack_err, 1'b1);
    wait_launch("to_launch2", 40, L2, d);
    check("to_launch2_cyc", L2, L + ACKT + GAP_LEN + 1 + RDL);
    check("to_data2", d, 8'h3C);
    wait_idle("to_idle1", 60);
    check("to_ack_sticky", ack_err, dead_seen);
    busy_len = 10;
    reset_dut();

    // rd_empty rises in the READ cycle.
    c0 = cyc;
    fifo_q.push_back(8'h44);
    refresh();
    tick();
    check("race_in_read", idle, 1'b0);
    force_empty = 1;
    refresh();
    r0 = reads;
    n0 = n_launch;
    #1 check("race_rd_req", rd_req, 1'b0);
    tick();
    check("race_idle_back", idle, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("race_no_read", reads, r0);
    check("race_no_launch", n_launch, n0);
    check("race_byte_cnt", byte_cnt, exp_cnt);
    fifo_q.delete();
    force_empty = 0;
    refresh();

    // Enable drop while draining.
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    refresh();
    wait_launch("drop_launch1", 20, L, d);
    check("drop_data1", d, 8'h11);
    tick();
    enable = 1'b0;
    r0 = reads;
    n0 = n_launch;
    while (cyc < L + 1 + busy_len + 1 + GAP_LEN) tick();
    check("drop_idle", idle, 1'b1);
    for (int i = 0; i < 30; i++) tick();
    check("drop_no_read", reads, r0);
    check("drop_no_launch", n_launch, n0);
    check("drop_fifo_kept", fifo_q.size(), 1);
    enable = 1'b1;
    wait_launch("drop_launch2", 20, L, d);
    check("drop_data2", d, 8'h22);

    // Reset in DRAIN.
    wait_idle("rstd_idle0", 60);
    fifo_q.push_back(8'h77);
    refresh();
    wait_launch("rstd_launch", 20, L, d);
    tick();
    tick();
    r0 = reads;
    rst = 1'b1;
    tick();
    check("rstd_idle", idle, 1'b1);
    check("rstd_byte_cnt", byte_cnt, 16'h0000);
    check("rstd_tx_data", tx_data, 8'h00);
    check("rstd_ack_err", ack_err, 1'b0);
    check("rstd_rd_req", rd_req, 1'b0);
    check("rstd_tx_start", tx_start, 1'b0);
    rst = 1'b0;
    exp_cnt = 16'h0000;
    dead_seen = 0;
    wait_idle("rstd_idle1", 60);
    check("rstd_no_read", reads, r0);

    // byte_cnt wrap from 0xFFFF.
    force dut.byte_cnt = 16'hFFFF;
    tick();
    release dut.byte_cnt;
    exp_cnt = 16'hFFFF;
    check("wrap_preload", byte_cnt, exp_cnt);
    fifo_q.push_back(8'h99);
    refresh();
    wait_launch("wrap_launch", 20, L, d);
    check("wrap_byte_cnt", byte_cnt, exp_cnt);
    wait_idle("wrap_idle", 60);

    // Randomized bytes, push times and busy lengths.
    reset_dut();
    rand_busy = 1;
    pushed = 0;
    prevc = -1000;
    for (int i = 0; i < 3000 && !(pushed == 12 && exp_q.size() == 0); i++) begin
      if (pushed < 12 && $urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        pushed++;
        refresh();
      end
      tick();
      while (log_q.size() != 0) begin
        e = log_q.pop_front();
        check("rand_has_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) check("rand_data", e.data, exp_q.pop_front());
        check("rand_spacing", (e.c - prevc >= MIN_SEP), 1'b1);
        check("rand_byte_cnt", byte_cnt, exp_cnt);
        prevc = e.c;
      end
    end
    check("rand_all_sent", exp_q.size(), 0);
    wait_idle("rand_idle", 60);
    check("rand_ack_err", ack_err, dead_seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
